// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM command interface (cache side and responder side).
package burst_ram_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam int unsigned BURST_BEAT_BITWIDTH = 64;

   // Defaults shared with the cache so both ends agree on burst shape and pacing.
   localparam int unsigned BURST_COUNT_DEFAULT      = 4;
   localparam int unsigned COMMAND_INTERVAL_DEFAULT = 14;

   // One-hot controller states.
   typedef enum logic [4:0] {
      StInit      = 5'b00001,
      StIdle      = 5'b00010,
      StWrite     = 5'b00100,
      StReadWait  = 5'b01000,
      StReadBurst = 5'b10000
   } burst_state_e;

endpackage

// File: rtl/burst_ram_mem.sv
// Single-port 64-bit RAM with per-byte write enables and a synchronous, hold-on-idle read port.
module burst_ram_mem
   import burst_ram_pkg::*;
#(
   parameter int unsigned ADDR_BITWIDTH = 12,
   parameter string       DATA_FILE     = ""
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_BITWIDTH-1:0]       addr,
   input  logic [BURST_BEAT_BITWIDTH/8-1:0] byte_we,
   input  logic [BURST_BEAT_BITWIDTH-1:0] wr_data,
   input  logic                           rd_en,
   output logic [BURST_BEAT_BITWIDTH-1:0] rd_data
);

   localparam int unsigned WORDS = 1 << ADDR_BITWIDTH;
   localparam int unsigned LANES = BURST_BEAT_BITWIDTH / 8;

   logic [BURST_BEAT_BITWIDTH-1:0] mem_q [WORDS];
   logic [BURST_BEAT_BITWIDTH-1:0] rd_data_q;

   // Byte-lane writes; reset deliberately leaves the array untouched.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (byte_we[i]) begin
            mem_q[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
         end
      end
   end

   // Read register only updates when a beat is fetched, so it holds the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/burst_ram.sv
// Burst RAM responder: fixed-length 64-bit bursts, command pacing and post-reset calibration delay.
module burst_ram
   import burst_ram_pkg::*;
#(
   parameter int unsigned DEPTH_BITWIDTH     = 21,
   parameter int unsigned ADDRESSING_MODE    = 0,
   parameter int unsigned MEM_WORDS_BITWIDTH = 12,
   parameter int unsigned BURST_COUNT        = BURST_COUNT_DEFAULT,
   parameter int unsigned READ_LATENCY       = 8,
   parameter int unsigned COMMAND_INTERVAL   = COMMAND_INTERVAL_DEFAULT,
   parameter int unsigned INIT_CYCLES        = 16,
   parameter string       DATA_FILE          = ""
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd,
   input  logic                           cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]      addr,
   input  logic [BURST_BEAT_BITWIDTH-1:0] wr_data,
   input  logic [BURST_BEAT_BITWIDTH/8-1:0] data_mask,
   output logic [BURST_BEAT_BITWIDTH-1:0] rd_data,
   output logic                           rd_data_valid,
   output logic                           init_calib,
   output logic                           cmd_error
);

   localparam int unsigned SHIFT   = 3 - ADDRESSING_MODE;
   localparam int unsigned BEAT_W  = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
   localparam int unsigned IVL_W   = $clog2(COMMAND_INTERVAL + 1);
   localparam int unsigned CNT_MAX = (INIT_CYCLES > READ_LATENCY) ? INIT_CYCLES : READ_LATENCY;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned EXT_W   = DEPTH_BITWIDTH + MEM_WORDS_BITWIDTH;

   localparam logic [MEM_WORDS_BITWIDTH-1:0] ALIGN_MASK = MEM_WORDS_BITWIDTH'(BURST_COUNT - 1);
   localparam logic [BEAT_W-1:0]             BEAT_LAST  = BEAT_W'(BURST_COUNT - 1);
   localparam logic [IVL_W-1:0]              IVL_LOAD   = IVL_W'(COMMAND_INTERVAL - 1);
   localparam logic [CNT_W-1:0]              INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]              WAIT_LAST  = CNT_W'(READ_LATENCY - 2);

   if (READ_LATENCY < 2) begin : g_chk_latency
      $error("burst_ram: READ_LATENCY must be at least 2");
   end
   if (BURST_COUNT == 0 || (BURST_COUNT & (BURST_COUNT - 1)) != 0) begin : g_chk_burst
      $error("burst_ram: BURST_COUNT must be a power of 2");
   end
   if (READ_LATENCY + BURST_COUNT > COMMAND_INTERVAL) begin : g_chk_interval
      $error("burst_ram: READ_LATENCY + BURST_COUNT exceeds COMMAND_INTERVAL");
   end
   if (ADDRESSING_MODE > 3) begin : g_chk_mode
      $error("burst_ram: ADDRESSING_MODE must be 0..3");
   end
   if (INIT_CYCLES < 1) begin : g_chk_init
      $error("burst_ram: INIT_CYCLES must be at least 1");
   end

   burst_state_e                  state_q;
   logic [CNT_W-1:0]              cnt_q;
   logic [BEAT_W-1:0]             beat_q;
   logic [IVL_W-1:0]              ivl_q;
   logic [MEM_WORDS_BITWIDTH-1:0] base_q;
   logic                          rd_data_valid_q;
   logic                          init_calib_q;
   logic                          cmd_error_q;

   logic                          accept;
   logic                          rejected;
   logic [MEM_WORDS_BITWIDTH-1:0] cmd_idx;
   logic [MEM_WORDS_BITWIDTH-1:0] beat_idx;
   logic [MEM_WORDS_BITWIDTH-1:0] mem_addr;
   logic [BURST_BEAT_BITWIDTH/8-1:0] mem_we;
   logic                          mem_re;

   // Accept/reject decode and burst-aligned, wrapped word index of the incoming command.
   always_comb begin
      accept   = !rst && cmd_en && (state_q == StIdle) && (ivl_q == '0);
      rejected = !rst && cmd_en && !accept;
      cmd_idx  = MEM_WORDS_BITWIDTH'(EXT_W'(addr) >> SHIFT) & ~ALIGN_MASK;
      // Base is aligned, so OR-ing the beat number never carries.
      beat_idx = base_q | MEM_WORDS_BITWIDTH'(beat_q);
   end

   // RAM port steering: beat 0 of a write uses the live command index, later beats the latched base.
   always_comb begin
      mem_addr = beat_idx;
      mem_we   = '0;
      mem_re   = 1'b0;
      if (accept && cmd == CMD_WRITE) begin
         mem_addr = cmd_idx;
         mem_we   = ~data_mask;
      end else if (!rst && state_q == StWrite) begin
         mem_we   = ~data_mask;
      end else if (!rst && state_q == StReadBurst) begin
         mem_re   = 1'b1;
      end
   end

   // Controller FSM with command-interval and beat counters; outputs registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StInit;
         cnt_q           <= '0;
         beat_q          <= '0;
         ivl_q           <= '0;
         base_q          <= '0;
         rd_data_valid_q <= 1'b0;
         init_calib_q    <= 1'b0;
         cmd_error_q     <= 1'b0;
      end else begin
         rd_data_valid_q <= 1'b0;
         cmd_error_q     <= rejected;
         if (accept) begin
            ivl_q <= IVL_LOAD;
         end else if (ivl_q != '0) begin
            ivl_q <= ivl_q - IVL_W'(1);
         end
         unique case (state_q)
            StInit: begin
               if (cnt_q == INIT_LAST) begin
                  state_q      <= StIdle;
                  init_calib_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StIdle: begin
               if (accept) begin
                  base_q <= cmd_idx;
                  cnt_q  <= '0;
                  if (cmd == CMD_WRITE) begin
                     beat_q  <= BEAT_W'(1);
                     state_q <= (BURST_COUNT > 1) ? StWrite : StIdle;
                  end else begin
                     beat_q  <= '0;
                     state_q <= StReadWait;
                  end
               end
            end
            StWrite: begin
               if (beat_q == BEAT_LAST) begin
                  state_q <= StIdle;
               end else begin
                  beat_q <= beat_q + BEAT_W'(1);
               end
            end
            StReadWait: begin
               if (cnt_q == WAIT_LAST) begin
                  state_q <= StReadBurst;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StReadBurst: begin
               // The RAM fetches this beat on the same edge, so valid and data line up.
               rd_data_valid_q <= 1'b1;
               if (beat_q == BEAT_LAST) begin
                  state_q <= StIdle;
               end else begin
                  beat_q <= beat_q + BEAT_W'(1);
               end
            end
            default: state_q <= StInit;
         endcase
      end
   end

   burst_ram_mem #(
      .ADDR_BITWIDTH (MEM_WORDS_BITWIDTH),
      .DATA_FILE     (DATA_FILE)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .addr    (mem_addr),
      .byte_we (mem_we),
      .wr_data (wr_data),
      .rd_en   (mem_re),
      .rd_data (rd_data)
   );

   assign rd_data_valid = rd_data_valid_q;
   assign init_calib    = init_calib_q;
   assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram: init timing, burst write/read, masking, alignment, wrap, pacing, reset.
module tb_burst_ram;

   logic        clk;
   logic        rst;
   logic        cmd;
   logic        cmd_en;
   logic [20:0] addr;
   logic [63:0] wr_data;
   logic [7:0]  data_mask;
   logic [63:0] rd_data;
   logic        rd_data_valid;
   logic        init_calib;
   logic        cmd_error;

   int n_vec;
   int n_err;
   int err_pulses;

   burst_ram #(
      .DEPTH_BITWIDTH     (21),
      .ADDRESSING_MODE    (0),
      .MEM_WORDS_BITWIDTH (12),
      .BURST_COUNT        (4),
      .READ_LATENCY       (8),
      .COMMAND_INTERVAL   (14),
      .INIT_CYCLES        (16),
      .DATA_FILE          ("")
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .init_calib    (init_calib),
      .cmd_error     (cmd_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every cycle cmd_error is seen high.
   always @(negedge clk) begin
      if (cmd_error === 1'b1) err_pulses++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles with init_calib low from the current cycle on; nothing else may be active.
   task automatic wait_calib(input string nm);
      int zeros;
      int noisy;
      zeros = 0;
      noisy = 0;
      for (int i = 0; i < 40 && init_calib !== 1'b1; i++) begin
         zeros++;
         if (rd_data_valid !== 1'b0 || cmd_error !== 1'b0) noisy++;
         tick();
      end
      check({nm, "_init_len"}, 64'(zeros), 64'd16);
      check({nm, "_init_calib"}, 64'(init_calib), 64'd1);
      check({nm, "_init_quiet"}, 64'(noisy), 64'd0);
   endtask

   // Accept edge, then three more beats; returns in the cycle after accept edge + 13.
   task automatic write_burst(input logic [20:0] a, input logic [3:0][63:0] d,
                              input logic [3:0][7:0] m, input bit poke);
      cmd  = 1'b1;
      addr = a;
      for (int k = 0; k < 4; k++) begin
         cmd_en    = (k == 0) || (poke && k == 1);
         wr_data   = d[k];
         data_mask = m[k];
         tick();
         if (poke && k == 1) check("wr_poke_err", 64'(cmd_error), 64'd1);
      end
      cmd_en    = 1'b0;
      data_mask = 8'hFF;
      repeat (10) tick();
   endtask

   // Read burst; optional rejected write attempt 13 edges after the accept.
   task automatic read_burst(input string nm, input logic [20:0] a, input logic [3:0][63:0] d,
                             input bit poke);
      int first;
      int last;
      int nv;
      logic [3:0][63:0] got;
      first  = -1;
      last   = -1;
      nv     = 0;
      got    = '0;
      cmd    = 1'b0;
      addr   = a;
      cmd_en = 1'b1;
      tick();
      cmd_en = 1'b0;
      for (int m = 1; m <= 13; m++) begin
         if (poke && m == 13) begin
            cmd       = 1'b1;
            cmd_en    = 1'b1;
            wr_data   = 64'h9999_9999_9999_9999;
            data_mask = 8'h00;
         end
         tick();
         if (poke && m == 13) begin
            cmd_en    = 1'b0;
            data_mask = 8'hFF;
            check({nm, "_rej_err"}, 64'(cmd_error), 64'd1);
         end
         if (rd_data_valid === 1'b1) begin
            if (first < 0) first = m;
            last = m;
            if (nv < 4) got[nv] = rd_data;
            nv++;
         end
      end
      check({nm, "_first"}, 64'(first), 64'd8);
      check({nm, "_last"}, 64'(last), 64'd11);
      check({nm, "_count"}, 64'(nv), 64'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_beat%0d", nm, k), got[k], d[k]);
      end
   endtask

   logic [3:0][63:0] d_a;
   logic [3:0][63:0] d_b_wr;
   logic [3:0][63:0] d_b_exp;
   logic [3:0][63:0] d_d;

   initial begin
      n_vec      = 0;
      n_err      = 0;
      err_pulses = 0;
      d_a     = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      d_b_wr  = {64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF,
                 64'hDEAD_BEEF_DEAD_BEEF, 64'hAAAA_AAAA_BBBB_BBBB};
      d_b_exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'hAAAA_AAAA_1111_1111};
      d_d     = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};

      rst       = 1'b1;
      cmd       = 1'b0;
      cmd_en    = 1'b0;
      addr      = '0;
      wr_data   = '0;
      data_mask = 8'hFF;
      repeat (3) tick();
      check("rst_valid", 64'(rd_data_valid), 64'd0);
      check("rst_calib", 64'(init_calib), 64'd0);
      check("rst_err", 64'(cmd_error), 64'd0);
      check("rst_data", rd_data, 64'd0);

      rst = 1'b0;
      wait_calib("a");

      // Plain write/read at byte address 0x40.
      write_burst(21'h40, d_a, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
      read_burst("a", 21'h40, d_a, 1'b0);

      // Masked overwrite of beat 0 only; beats 1-3 fully masked; stray cmd_en mid-burst.
      write_burst(21'h40, d_b_wr, {8'hFF, 8'hFF, 8'hFF, 8'h0F}, 1'b1);
      read_burst("b", 21'h40, d_b_exp, 1'b0);

      // Unaligned start address maps onto the same burst.
      read_burst("c", 21'h47, d_b_exp, 1'b0);

      // Word index 4096 + 8 wraps onto index 8.
      write_burst(21'h8040, d_d, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
      read_burst("d", 21'h40, d_d, 1'b0);

      // Command 13 edges after accept is rejected; retry at 14 is accepted and memory is untouched.
      read_burst("e1", 21'h40, d_d, 1'b1);
      read_burst("e2", 21'h40, d_d, 1'b0);

      // Reset in the second read beat.
      cmd    = 1'b0;
      addr   = 21'h40;
      cmd_en = 1'b1;
      tick();
      cmd_en = 1'b0;
      repeat (8) tick();
      check("f_valid0", 64'(rd_data_valid), 64'd1);
      check("f_beat0", rd_data, d_d[0]);
      tick();
      check("f_valid1", 64'(rd_data_valid), 64'd1);
      check("f_beat1", rd_data, d_d[1]);
      rst = 1'b1;
      tick();
      check("f_rst_valid", 64'(rd_data_valid), 64'd0);
      check("f_rst_calib", 64'(init_calib), 64'd0);
      check("f_rst_data", rd_data, 64'd0);
      rst = 1'b0;
      wait_calib("f");

      // Memory survives reset.
      read_burst("g", 21'h40, d_d, 1'b0);

      check("err_pulses", 64'(err_pulses), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
